mem_stage: RTL
==============

# mem_stage

Memory-access stage of the five-stage pipeline, directly downstream of the execute stage. Registers the execute results (EX/MEM boundary), performs word loads and stores against an internal data memory with configurable multi-cycle latency, resolves taken branches, and presents one retired instruction per completion to write-back. While an access is in flight it raises `mem_busy` so the hazard unit freezes the upstream stages.

## Interface
- `DEPTH_WORDS`, 256: data memory size in 32-bit words; power of two.
- `MEM_LAT`, 2: cycles from capture edge to access completion; legal range 1..15.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `stall_flag`  in  1  global freeze from hazard unit; 1 = hold all state.
- `ex_valid`  in  1  execute stage presents an instruction.
- `alu_result`  in  32  ALU result; byte address for loads and stores.
- `store_data`  in  32  rt value for stores.
- `mem_read`, `mem_write`, `reg_write`, `branch`, `zero`  in  1 each  control from execute stage.
- `dest_reg`  in  5  destination register.
- `branch_target`  in  32  pc + (sign_ext<<2) from execute stage.
- `mem_busy`  out  1  access in flight; upstream must hold its outputs.
- `wb_valid`  out  1  one-cycle pulse per retired instruction.
- `wb_reg_write`  out  1  write-back enable, qualified by `wb_valid`.
- `wb_dest`  out  5  destination register.
- `wb_data`  out  32  load data or ALU result.
- `pc_src`  out  1  one-cycle pulse: branch taken.
- `pc_branch`  out  32  target PC, valid with `pc_src`.
- `misaligned`  out  1  one-cycle pulse: memory op with `alu_result[1:0]` != 0.

## Operation
- States: IDLE, ACCESS. Reset: IDLE, counter 0, every output 0.
- `stall_flag`=1: no register, counter, memory or output changes; the edge is ignored.
- IDLE, `ex_valid`=1: capture all inputs.
  - No memory op: retire same edge: `wb_valid`=1, `wb_data`=`alu_result`, `wb_reg_write`=`reg_write`.
  - Memory op, aligned: enter ACCESS, counter = MEM_LAT-1, `mem_busy`=1.
  - Memory op, misaligned: no access; retire same edge with `misaligned`=1, `wb_reg_write`=0.
  - `branch`&&`zero`: `pc_src`=1, `pc_branch`=`branch_target`, same edge as capture.
- ACCESS: `ex_valid` ignored. Counter decrements each unstalled edge; on the edge where it is 0: load reads `mem[idx]` into `wb_data`, store writes `store_data` to `mem[idx]`; retire (`wb_valid`=1; `wb_reg_write` = `reg_write` for loads, 0 for stores); return to IDLE; `mem_busy`=0.
- `idx` = `alu_result[log2(DEPTH_WORDS)+1:2]`; upper address bits ignored (wrap).
- `mem_read` and `mem_write` both 1: read performed, write suppressed.
- Pulsed outputs (`wb_valid`, `pc_src`, `misaligned`) clear on the next unstalled edge.
- Memory contents are not reset.

## Timing
- ALU op: outputs visible 1 cycle after capture edge.
- Load/store: `mem_busy` high exactly MEM_LAT cycles (unstalled); result visible MEM_LAT cycles after capture edge.
- Stall cycles extend all latencies one-for-one.
- Reset mid-access: immediate return to IDLE; in-flight store is discarded (memory untouched, since the write occurs only at completion).
- A new instruction may be captured on the edge after the completion edge; throughput is 1 per cycle for ALU ops.

## Structure
- Shared pipeline package: state enum (IDLE, ACCESS), MEM_LAT default, control-bundle struct (`mem_read`, `mem_write`, `reg_write`, `branch`, `dest_reg`) shared with the execute stage.
- One sub-module, `data_mem`: synchronous word array, single port, write enable, registered read.

## Test plan
- Reset, then ALU op `alu_result`=0x2A, `reg_write`=1, `dest_reg`=5 -> next cycle `wb_valid`=1, `wb_data`=0x2A, `wb_dest`=5, `mem_busy`=0.
- Store 0xDEADBEEF at 0x10, then load 0x10 (MEM_LAT=2) -> `mem_busy` high 2 cycles for each; load retires with `wb_data`=0xDEADBEEF, `wb_reg_write`=1.
- Load at 0x13 -> no access, `misaligned`=1 and `wb_valid`=1 for one cycle, `wb_reg_write`=0.
- `branch`=1, `zero`=1, `branch_target`=0x40 -> `pc_src`=1, `pc_branch`=0x40 for exactly one cycle; with `zero`=0 -> `pc_src` stays 0.
- Load issued, `stall_flag`=1 for 3 cycles mid-access -> `mem_busy` high 5 cycles, single `wb_valid` pulse.
- Store 0x1 to 0x20 with `reset` asserted during ACCESS -> outputs 0, state IDLE; later load 0x20 returns the pre-store value.

Source files
------------

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// mem_stage_pkg -- pipeline types shared by the execute and memory stages (rev 1.0)
package mem_stage_pkg;

  localparam int MEM_LAT_DEFAULT = 2;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       branch;
    logic [4:0] dest_reg;
  } ctrl_t;

  function automatic logic word_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_data_mem.sv
`default_nettype none
// data_mem -- single-port synchronous word RAM with write enable and registered read (rev 1.0)
module data_mem #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           we,
  input  logic                           re,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Array contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// mem_stage -- EX/MEM register, multi-cycle data memory access, branch resolve, retire to WB (rev 1.0)
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int MEM_LAT     = MEM_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_flag,
  input  logic        ex_valid,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic        branch,
  input  logic        zero,
  input  logic [4:0]  dest_reg,
  input  logic [31:0] branch_target,
  output logic        mem_busy,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic        pc_src,
  output logic [31:0] pc_branch,
  output logic        misaligned
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

  mem_state_t state, next_state;
  ctrl_t      w_ctrl;

  logic          r_mem_read, r_mem_write, r_reg_write, r_load_sel;
  logic [4:0]    r_dest;
  logic [31:0]   r_addr, r_sdata, r_wb_word;
  logic [3:0]    r_cnt;
  logic [31:0]   w_mem_q;
  logic [AW-1:0] w_mem_idx;
  logic          w_capture, w_is_memop, w_aligned, w_complete, w_mem_we, w_mem_re;

  always_comb begin
    w_ctrl.mem_read  = mem_read;
    w_ctrl.mem_write = mem_write;
    w_ctrl.reg_write = reg_write;
    w_ctrl.branch    = branch;
    w_ctrl.dest_reg  = dest_reg;
  end

  assign w_capture  = (state == IDLE) && ex_valid && !stall_flag;
  assign w_is_memop = w_ctrl.mem_read || w_ctrl.mem_write;
  assign w_aligned  = word_aligned(alu_result[1:0]);
  assign w_complete = (state == ACCESS) && (r_cnt == 4'd0) && !stall_flag;

  // Memory is touched only on the completion edge; a read wins over a simultaneous write.
  assign w_mem_idx = r_addr[AW+1:2];
  assign w_mem_re  = w_complete && r_mem_read;
  assign w_mem_we  = w_complete && r_mem_write && !r_mem_read;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (w_capture && w_is_memop && w_aligned) next_state = ACCESS;
      ACCESS:  if (w_complete) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_reg_write  <= 1'b0;
      r_dest       <= '0;
      r_addr       <= '0;
      r_sdata      <= '0;
      r_cnt        <= '0;
      r_wb_word    <= '0;
      r_load_sel   <= 1'b0;
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      wb_dest      <= '0;
      pc_src       <= 1'b0;
      pc_branch    <= '0;
      misaligned   <= 1'b0;
    end else if (!stall_flag) begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      pc_src       <= 1'b0;
      misaligned   <= 1'b0;
      if (w_capture) begin
        r_mem_read  <= w_ctrl.mem_read;
        r_mem_write <= w_ctrl.mem_write;
        r_reg_write <= w_ctrl.reg_write;
        r_dest      <= w_ctrl.dest_reg;
        r_addr      <= alu_result;
        r_sdata     <= store_data;
        if (w_ctrl.branch && zero) begin
          pc_src    <= 1'b1;
          pc_branch <= branch_target;
        end
        if (!w_is_memop || !w_aligned) begin
          wb_valid     <= 1'b1;
          wb_reg_write <= w_ctrl.reg_write && !w_is_memop;
          misaligned   <= w_is_memop;
          wb_dest      <= w_ctrl.dest_reg;
          r_wb_word    <= alu_result;
          r_load_sel   <= 1'b0;
        end else begin
          r_cnt <= LAT_INIT;
        end
      end else if (state == ACCESS) begin
        if (r_cnt == 4'd0) begin
          wb_valid     <= 1'b1;
          wb_reg_write <= r_mem_read && r_reg_write;
          wb_dest      <= r_dest;
          r_wb_word    <= r_addr;
          r_load_sel   <= r_mem_read;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

  // Load data comes straight from the RAM's read register, which holds until the next load.
  assign wb_data  = r_load_sel ? w_mem_q : r_wb_word;
  assign mem_busy = (state == ACCESS);

  data_mem #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_data_mem (
    .clk  (clk),
    .reset(reset),
    .we   (w_mem_we),
    .re   (w_mem_re),
    .addr (w_mem_idx),
    .wdata(r_sdata),
    .rdata(w_mem_q)
  );

endmodule
`default_nettype wire
